// File: rtl/code_lock_pkg.sv
// Shared types and width helpers for the code lock controller.
package code_lock_pkg;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_PROG    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  // digit_cnt must hold 0..DIGITS
  function automatic int cnt_w(input int digits);
    return $clog2(digits + 1);
  endfunction

  // tries_left must hold 0..MAX_TRIES
  function automatic int tries_w(input int max_tries);
    return $clog2(max_tries + 1);
  endfunction

  // lockout counter must hold 0..LOCK_CYCLES
  function automatic int lock_w(input int lock_cycles);
    return $clog2(lock_cycles + 1);
  endfunction

endpackage

// File: rtl/code_lock_ctrl_lockout_timer.sv
// Load/count-down lockout timer; done is high during the last counted cycle
// so the controller leaves lockout on the edge that ends it.
module lockout_timer
  import code_lock_pkg::*;
#(
  parameter int LOCK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam int LW = lock_w(LOCK_CYCLES);

  logic [LW-1:0] cnt;

  // load to LOCK_CYCLES, then count down to zero and rest there
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= LW'(LOCK_CYCLES);
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign done = (cnt == LW'(1));

endmodule

// File: rtl/code_lock_ctrl.sv
// Code lock controller: MSB-first digit entry, try counting with timed
// lockout, and code reprogramming while open.
module code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int DIGIT_W     = 2,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16,
  parameter logic [DIGITS*DIGIT_W-1:0] INIT_CODE = 'hE4
) (
  input  logic                          btnclk,
  input  logic                          rst,
  input  logic [DIGIT_W-1:0]            din,
  input  logic                          din_valid,
  input  logic                          clr,
  input  logic                          prog,
  output logic                          pass,
  output logic                          fail,
  output logic                          open,
  output logic                          locked,
  output logic                          prog_done,
  output logic [cnt_w(DIGITS)-1:0]      digit_cnt,
  output logic [tries_w(MAX_TRIES)-1:0] tries_left
);

  localparam int CW     = cnt_w(DIGITS);
  localparam int TW     = tries_w(MAX_TRIES);
  localparam int CODE_W = DIGITS * DIGIT_W;
  // the final digit comes straight from din, so only DIGITS-1 are buffered
  localparam int SH_W   = CODE_W - DIGIT_W;

  state_t              state;
  logic [CODE_W-1:0]   code;
  logic [SH_W-1:0]     shadow;
  logic [CODE_W-1:0]   shadow_nxt;
  logic                err;
  logic [DIGIT_W-1:0]  exp_digit;
  logic                last;
  logic                bad;
  logic                lock_load;
  logic                tmr_done;

  // expected digit for the current position, plus outcome of this strobe
  always_comb begin
    exp_digit = '0;
    for (int k = 0; k < DIGITS; k++)
      if (digit_cnt == CW'(k)) exp_digit = code[(DIGITS-1-k)*DIGIT_W +: DIGIT_W];
    last       = (digit_cnt == CW'(DIGITS - 1));
    bad        = err | (din != exp_digit);
    shadow_nxt = {shadow, din};
    lock_load  = (state == ST_ENTRY) & din_valid & ~clr & last & bad &
                 (tries_left <= TW'(1));
  end

  lockout_timer #(.LOCK_CYCLES(LOCK_CYCLES)) u_tmr (
    .clk  (btnclk),
    .rst  (rst),
    .load (lock_load),
    .done (tmr_done)
  );

  // main controller; all outputs are registered here
  always_ff @(posedge btnclk or posedge rst) begin
    if (rst) begin
      state      <= ST_ENTRY;
      code       <= INIT_CODE;
      shadow     <= '0;
      err        <= 1'b0;
      digit_cnt  <= '0;
      tries_left <= TW'(MAX_TRIES);
      pass       <= 1'b0;
      fail       <= 1'b0;
      prog_done  <= 1'b0;
      open       <= 1'b0;
      locked     <= 1'b0;
    end else begin
      pass      <= 1'b0;
      fail      <= 1'b0;
      prog_done <= 1'b0;
      case (state)
        ST_ENTRY: begin
          if (clr) begin
            digit_cnt <= '0;
            err       <= 1'b0;
          end else if (din_valid) begin
            if (last) begin
              // judge only after the full code so partial codes can't be probed
              digit_cnt <= '0;
              err       <= 1'b0;
              if (bad) begin
                fail <= 1'b1;
                if (tries_left <= TW'(1)) begin
                  tries_left <= '0;
                  state      <= ST_LOCKOUT;
                  locked     <= 1'b1;
                end else begin
                  tries_left <= tries_left - 1'b1;
                end
              end else begin
                pass       <= 1'b1;
                tries_left <= TW'(MAX_TRIES);
                state      <= ST_OPEN;
                open       <= 1'b1;
              end
            end else begin
              digit_cnt <= digit_cnt + 1'b1;
              err       <= bad;
            end
          end
        end
        ST_OPEN: begin
          if (clr) begin
            state <= ST_ENTRY;
            open  <= 1'b0;
          end else if (din_valid && prog) begin
            state     <= ST_PROG;
            shadow    <= SH_W'(din);
            digit_cnt <= CW'(1);
          end
        end
        ST_PROG: begin
          if (clr) begin
            state     <= ST_OPEN;
            digit_cnt <= '0;
          end else if (din_valid) begin
            if (last) begin
              code      <= shadow_nxt;
              prog_done <= 1'b1;
              state     <= ST_OPEN;
              digit_cnt <= '0;
            end else begin
              shadow    <= shadow_nxt[SH_W-1:0];
              digit_cnt <= digit_cnt + 1'b1;
            end
          end
        end
        ST_LOCKOUT: begin
          if (tmr_done) begin
            state      <= ST_ENTRY;
            locked     <= 1'b0;
            tries_left <= TW'(MAX_TRIES);
          end
        end
        default: state <= ST_ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Scoreboard bench for code_lock_ctrl: a default instance (4x2-bit, 3 tries,
// 16-cycle lockout) and a 6x4-bit, single-try, 5-cycle-lockout instance.
module tb_code_lock_ctrl;

  localparam int K_PASS = 0;
  localparam int K_FAIL = 1;
  localparam int K_PD   = 2;

  typedef struct {
    int   kind;
    int   due;
    logic op;
    logic lk;
    int   tl;
  } exp_t;

  logic btnclk = 1'b0;
  logic rst    = 1'b1;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  exp_t qa[$];
  exp_t qb[$];

  // instance A
  logic [1:0] din_a = '0;
  logic       dv_a = 0, clr_a = 0, prog_a = 0;
  logic       pass_a, fail_a, open_a, locked_a, pd_a;
  logic [2:0] dc_a;
  logic [1:0] tl_a;

  // instance B
  logic [3:0] din_b = '0;
  logic       dv_b = 0, clr_b = 0, prog_b = 0;
  logic       pass_b, fail_b, open_b, locked_b, pd_b;
  logic [2:0] dc_b;
  logic [0:0] tl_b;

  always #5 btnclk = ~btnclk;
  always @(posedge btnclk) cyc <= cyc + 1;

  code_lock_ctrl dut_a (
    .btnclk(btnclk), .rst(rst), .din(din_a), .din_valid(dv_a), .clr(clr_a),
    .prog(prog_a), .pass(pass_a), .fail(fail_a), .open(open_a),
    .locked(locked_a), .prog_done(pd_a), .digit_cnt(dc_a), .tries_left(tl_a)
  );

  code_lock_ctrl #(
    .DIGITS(6), .DIGIT_W(4), .MAX_TRIES(1), .LOCK_CYCLES(5),
    .INIT_CODE(24'h1A2B3C)
  ) dut_b (
    .btnclk(btnclk), .rst(rst), .din(din_b), .din_valid(dv_b), .clr(clr_b),
    .prog(prog_b), .pass(pass_b), .fail(fail_b), .open(open_b),
    .locked(locked_b), .prog_done(pd_b), .digit_cnt(dc_b), .tries_left(tl_b)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // monitor A: every pulse must match the oldest pending expectation
  always @(negedge btnclk) begin
    exp_t e;
    int   k;
    if (!rst && (pass_a || fail_a || pd_a)) begin
      k = pass_a ? K_PASS : (fail_a ? K_FAIL : K_PD);
      chk("a_single_pulse", int'(pass_a) + int'(fail_a) + int'(pd_a), 1);
      chk("a_pulse_expected", qa.size() > 0, 1);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_kind", k, e.kind);
        chk("a_cycle", cyc, e.due);
        chk("a_open", open_a, e.op);
        chk("a_locked", locked_a, e.lk);
        chk("a_tries", tl_a, e.tl);
      end
    end
  end

  // monitor B
  always @(negedge btnclk) begin
    exp_t e;
    int   k;
    if (!rst && (pass_b || fail_b || pd_b)) begin
      k = pass_b ? K_PASS : (fail_b ? K_FAIL : K_PD);
      chk("b_single_pulse", int'(pass_b) + int'(fail_b) + int'(pd_b), 1);
      chk("b_pulse_expected", qb.size() > 0, 1);
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("b_kind", k, e.kind);
        chk("b_cycle", cyc, e.due);
        chk("b_open", open_b, e.op);
        chk("b_locked", locked_b, e.lk);
        chk("b_tries", tl_b, e.tl);
      end
    end
  end

  // one strobe on A; optionally queue the response expected after it
  task automatic sa(input logic [1:0] d, input logic pr = 1'b0, input bit push = 1'b0,
                    input int kind = 0, input logic op = 1'b0, input logic lk = 1'b0,
                    input int tl = 0);
    exp_t e;
    @(negedge btnclk);
    din_a = d; prog_a = pr; dv_a = 1'b1;
    if (push) begin
      e.kind = kind; e.due = cyc + 1; e.op = op; e.lk = lk; e.tl = tl;
      qa.push_back(e);
    end
    @(posedge btnclk);
    #1 dv_a = 1'b0; prog_a = 1'b0;
  endtask

  task automatic enter_a(input logic [7:0] c, input int kind, input logic op,
                         input logic lk, input int tl);
    for (int i = 0; i < 4; i++)
      sa(c[7-2*i -: 2], 1'b0, i == 3, kind, op, lk, tl);
  endtask

  task automatic sb(input logic [3:0] d, input bit push, input int kind,
                    input logic op, input logic lk, input int tl);
    exp_t e;
    @(negedge btnclk);
    din_b = d; dv_b = 1'b1;
    if (push) begin
      e.kind = kind; e.due = cyc + 1; e.op = op; e.lk = lk; e.tl = tl;
      qb.push_back(e);
    end
    @(posedge btnclk);
    #1 dv_b = 1'b0;
  endtask

  task automatic enter_b(input logic [23:0] c, input int kind, input logic op,
                         input logic lk, input int tl);
    for (int i = 0; i < 6; i++)
      sb(c[23-4*i -: 4], i == 5, kind, op, lk, tl);
  endtask

  task automatic clr_a_pulse();
    @(negedge btnclk);
    clr_a = 1'b1;
    @(posedge btnclk);
    #1 clr_a = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) @(negedge btnclk);
    rst = 1'b0;

    // reset state
    chk("rst_pass", pass_a, 0);
    chk("rst_fail", fail_a, 0);
    chk("rst_prog_done", pd_a, 0);
    chk("rst_open", open_a, 0);
    chk("rst_locked", locked_a, 0);
    chk("rst_digit_cnt", dc_a, 0);
    chk("rst_tries", tl_a, 3);
    chk("rst_b_tries", tl_b, 1);

    // correct default code 3,2,1,0
    enter_a(8'hE4, K_PASS, 1'b1, 1'b0, 3);
    chk("open_after_pass", open_a, 1);
    clr_a_pulse();
    chk("open_after_clr", open_a, 0);

    // wrong code 3,0,1,0: nothing reported until the 4th digit
    sa(2'd3);
    sa(2'd0);
    chk("no_early_reject_cnt", dc_a, 2);
    chk("no_early_reject_fail", fail_a, 0);
    sa(2'd1);
    sa(2'd0, 1'b0, 1'b1, K_FAIL, 1'b0, 1'b0, 2);

    // two digits then clr together with a strobe: entry aborted, no try used
    sa(2'd3);
    sa(2'd2);
    @(negedge btnclk);
    clr_a = 1'b1; dv_a = 1'b1; din_a = 2'd1;
    @(posedge btnclk);
    #1 clr_a = 1'b0; dv_a = 1'b0;
    chk("clr_cnt", dc_a, 0);
    chk("clr_tries", tl_a, 2);
    enter_a(8'hE4, K_PASS, 1'b1, 1'b0, 3);

    // reprogram to 0,1,2,3
    sa(2'd0, 1'b1);
    chk("prog_open", open_a, 1);
    chk("prog_cnt", dc_a, 1);
    sa(2'd1, 1'b1);
    sa(2'd2, 1'b1);
    sa(2'd3, 1'b1, 1'b1, K_PD, 1'b1, 1'b0, 3);
    clr_a_pulse();
    enter_a(8'hE4, K_FAIL, 1'b0, 1'b0, 2);
    enter_a(8'h1B, K_PASS, 1'b1, 1'b0, 3);
    clr_a_pulse();

    // three failures -> lockout
    enter_a(8'h00, K_FAIL, 1'b0, 1'b0, 2);
    enter_a(8'h00, K_FAIL, 1'b0, 1'b0, 1);
    enter_a(8'h00, K_FAIL, 1'b0, 1'b1, 0);
    chk("lock_rise", locked_a, 1);
    for (int k = 0; k < 16; k++) begin
      @(negedge btnclk);
      din_a = 2'd3; dv_a = 1'b1;
      chk("lock_hold", locked_a, 1);
      chk("lock_ignores_strobe", dc_a, 0);
    end
    @(negedge btnclk);
    chk("lock_end", locked_a, 0);
    chk("lock_end_tries", tl_a, 3);
    chk("lock_end_cnt", dc_a, 0);
    // strobe on the first unlocked cycle must be accepted
    din_a = 2'd0; dv_a = 1'b1;
    @(posedge btnclk);
    #1 dv_a = 1'b0;
    sa(2'd1);
    sa(2'd2);
    sa(2'd3, 1'b0, 1'b1, K_PASS, 1'b1, 1'b0, 3);

    // reset mid-PROG restores the original code
    sa(2'd0, 1'b1);
    sa(2'd1, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_open", open_a, 0);
    chk("rst_mid_cnt", dc_a, 0);
    @(negedge btnclk);
    rst = 1'b0;
    enter_a(8'hE4, K_PASS, 1'b1, 1'b0, 3);

    // wide instance: single try locks immediately, then correct code passes
    enter_b(24'h1A2B30, K_FAIL, 1'b0, 1'b1, 0);
    chk("b_lock_rise", locked_b, 1);
    n = 0;
    do begin
      @(negedge btnclk);
      n++;
    end while (locked_b && n < 20);
    chk("b_lock_len", n, 6);
    chk("b_tries_reload", tl_b, 1);
    enter_b(24'h1A2B3C, K_PASS, 1'b1, 1'b0, 1);

    repeat (3) @(negedge btnclk);
    chk("a_no_missing_pulse", qa.size(), 0);
    chk("b_no_missing_pulse", qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/code_lock_ctrl.md
# code_lock_ctrl

Parametrised successor to the fixed 4-digit, 2-bit password checker in the lock datapath. It accepts `DIGITS` entries of `DIGIT_W` bits via a strobe, compares them against an internally stored code, and reports pass/fail. It also counts failed attempts into a timed lockout and lets the user reprogram the code once the lock is open. It sits between the debounced keypad/switch front end and the LED/seven-segment status logic.

## Interface
- `DIGITS`, 4: digits per code (≥2).
- `DIGIT_W`, 2: bits per digit (≥1).
- `MAX_TRIES`, 3: consecutive failed attempts before lockout (≥1).
- `LOCK_CYCLES`, 16: lockout duration in `btnclk` cycles (≥1).
- `INIT_CODE`, `'hE4`: `DIGITS*DIGIT_W`-bit code loaded at reset.

Ports:
- `btnclk` in 1: single clock, all flops on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `din` in `DIGIT_W`: digit value, sampled when `din_valid`=1.
- `din_valid` in 1: one-cycle entry strobe.
- `clr` in 1: abort the current entry; closes the lock when open.
- `prog` in 1: while open, a `din_valid` with `prog`=1 starts reprogramming.
- `pass` out 1: one-cycle pulse, correct code entered.
- `fail` out 1: one-cycle pulse, wrong code entered.
- `open` out 1: level, lock open (OPEN or PROG).
- `locked` out 1: level, lockout active.
- `prog_done` out 1: one-cycle pulse, new code stored.
- `digit_cnt` out `$clog2(DIGITS+1)`: digits taken in the current entry.
- `tries_left` out `$clog2(MAX_TRIES+1)`: remaining attempts.

## Operation
- States are ENTRY, OPEN, PROG and LOCKOUT. Reset state is ENTRY.
- Digit order is MSB first. Entry k (0-based) compares against `code[(DIGITS-1-k)*DIGIT_W +: DIGIT_W]`.
- ENTRY:
  - Each `din_valid` increments `digit_cnt`. Any mismatch sets a sticky `err` flag.
  - The FSM always consumes all `DIGITS` digits. It gives no early rejection, so partial codes cannot be probed.
  - On the last digit, the outcome is judged on (err OR last-digit mismatch):
    - Match: `pass` pulses, `tries_left` reloads to `MAX_TRIES`, next state is OPEN.
    - Mismatch: `fail` pulses and `tries_left` decrements. If it reaches 0, next state is LOCKOUT; otherwise stay in ENTRY.
  - `digit_cnt` and `err` clear after the last digit in either case.
- OPEN:
  - `clr` returns to ENTRY.
  - `din_valid` with `prog`=1 moves to PROG, and that digit is captured as new digit 0.
  - `din_valid` with `prog`=0 is ignored.
- PROG:
  - Digits shift into a shadow register.
  - On digit `DIGITS`, the shadow is copied to the code register, `prog_done` pulses, and the state returns to OPEN.
  - `clr` in PROG discards the shadow; the code is unchanged and the state returns to OPEN.
- LOCKOUT:
  - `locked`=1 and every `din_valid` is ignored.
  - The timer counts `LOCK_CYCLES` cycles. It then reloads `tries_left` to `MAX_TRIES` and returns to ENTRY. `clr` does not shorten the lockout.
- In ENTRY, `clr` zeroes `digit_cnt` and `err` but does not consume a try.
- `clr` and `din_valid` in the same cycle: `clr` wins and the digit is dropped.
- `MAX_TRIES`=1: the first failure enters LOCKOUT directly.

## Timing
- Reset values: `pass`=0, `fail`=0, `prog_done`=0, `open`=0, `locked`=0, `digit_cnt`=0, `tries_left`=`MAX_TRIES`, code=`INIT_CODE`, state=ENTRY.
- Reset mid-entry, mid-PROG or mid-LOCKOUT restores every reset value immediately, including the code.
- All outputs are registered.
  - `pass`, `fail` and `prog_done` are high for exactly the one cycle after the edge that sampled the final digit.
  - `open` and `locked` change at that same edge as the pulse.
- Lockout: `locked` rises with the final `fail` pulse and stays high for exactly `LOCK_CYCLES` cycles. A `din_valid` on the first cycle with `locked`=0 is accepted.
- Back-to-back `din_valid` on consecutive cycles is supported with no dead cycles, except during LOCKOUT.

## Structure
- The shared package `code_lock_pkg` holds:
  - the state enum (`ST_ENTRY`, `ST_OPEN`, `ST_PROG`, `ST_LOCKOUT`);
  - the width helpers for `digit_cnt`, `tries_left` and the lockout counter (`$clog2(LOCK_CYCLES+1)`).
- One sub-module, `lockout_timer`: a load/count-down counter with a `done` pulse, parametrised by `LOCK_CYCLES`.

## Test plan
- Default code `'hE4`, enter 3,2,1,0 → `pass` pulse one cycle after the 4th strobe, `open`=1, `fail`=0.
- Enter 3,0,1,0 → no reaction after the 2nd digit; `fail` pulses after the 4th; `tries_left` goes 3→2; `open`=0.
- Three wrong codes → the 3rd `fail` coincides with `locked`=1. Strobes during the 16 cycles are ignored (`digit_cnt` stays 0). At cycle 17 `locked`=0, `tries_left`=3, and a correct code passes.
- From OPEN, `prog`=1 with 0,1,2,3 → `prog_done` pulse. `clr`, then 3,2,1,0 fails and 0,1,2,3 passes.
- Enter 2 digits, then `clr` coincident with a strobe → `digit_cnt`=0, `tries_left` unchanged. Assert `rst` mid-PROG → code reverts to `'hE4`.
- Parametrised run with `DIGITS`=6, `DIGIT_W`=4, `MAX_TRIES`=1 → the first failure locks immediately; a correct 6-digit code passes.
